peridot_rxd_packetizer: RTL and testbench
=========================================

# peridot_rxd_packetizer

- Sits directly downstream of the UART receiver phy.
- Turns its raw byte stream, which has no backpressure, into an Avalon-ST packet stream with SOP, EOP and channel, using the escape-coded framing used on the PERIDOT host link.
- Buffers decoded bytes in a small FIFO so a stalling consumer does not lose data, and flags overflow when it does.

## Interface
Parameters:
- CHANNEL_WIDTH, 8: width of out_channel (1..8); the channel byte is truncated to its LSBs.
- FIFO_DEPTH_LOG2, 4: FIFO depth is 2^FIFO_DEPTH_LOG2 entries (2..8).

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock, all logic on rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: one-cycle strobe, byte present. No ready; a byte is never refused.
- in_data, in, 8: received byte.
- out_valid, out, 1: decoded byte available.
- out_ready, in, 1: consumer accepts; a transfer occurs when out_valid && out_ready.
- out_data, out, 8: decoded payload byte.
- out_startofpacket, out, 1: first byte of a packet.
- out_endofpacket, out, 1: last byte of a packet.
- out_channel, out, CHANNEL_WIDTH: channel of this byte.
- err_overflow, out, 1: one-cycle pulse when a decoded byte is dropped.

## Operation
Special bytes:
- 0x7A: SOP marker.
- 0x7B: EOP marker.
- 0x7C: channel prefix.
- 0x7D: escape; the next byte is XOR 0x20.

Decoder FSM advances only on in_valid. Cycles with in_valid=0 change nothing.
- NORMAL:
  - 0x7A: set sop_pend.
  - 0x7B: set eop_pend.
  - 0x7C: go to CHAN.
  - 0x7D: go to ESC.
  - any other byte: push it as data.
- ESC: push in_data^0x20 as data, then go to NORMAL. Specials are not reinterpreted here.
- CHAN:
  - 0x7D: go to CHAN_ESC.
  - any other byte: cur_chan <= in_data[CHANNEL_WIDTH-1:0], then go to NORMAL.
- CHAN_ESC: cur_chan <= (in_data^0x20)[CHANNEL_WIDTH-1:0], then go to NORMAL.

Push rules:
- A push writes {sop_pend, eop_pend, cur_chan, byte} into the FIFO and clears sop_pend and eop_pend.
- Pending flags persist across any number of markers. Repeated 0x7A is idempotent.
- cur_chan persists until the next channel byte.
- Overflow: a push while the FIFO is full and not being read in the same cycle drops the entry. Flags are still cleared, and err_overflow=1 for that cycle.
- A push while full with a simultaneous out_valid && out_ready is accepted.

FIFO and output:
- The FIFO is first-word-fall-through.
- Output fields are registers holding the head entry; they are stable while out_valid && !out_ready.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, err_overflow=0.
  - Internal: FSM=NORMAL, sop_pend=0, eop_pend=0, cur_chan=0, FIFO empty.
- Latency: a data byte with in_valid at cycle N is written at the edge ending N. out_valid=1 from cycle N+1 if the FIFO was empty. There is no combinational in-to-out path.
- Throughput: one pop per cycle while out_ready=1 and the FIFO is non-empty. Back-to-back in_valid (every cycle) must be sustained.
- Pointers: wrap modulo 2^FIFO_DEPTH_LOG2. Full/empty are distinguished by an extra pointer MSB.
- Reset asserted mid-packet: everything is cleared immediately. The FIFO content and partial escape/channel state are discarded. err_overflow is not raised.

## Configuration
Macro PERIDOT_RXD_PACKETIZER_CHANNEL_EN.
- Defined: channel decoding works as above.
- Undefined:
  - CHAN and CHAN_ESC still consume the following byte, including escape handling, but discard it.
  - cur_chan is absent, and out_channel is constant 0.
  - The FIFO word narrows to 10 bits.

## Structure
- Shared package peridot_pkt_pkg holds:
  - constants for 0x7A, 0x7B, 0x7C, 0x7D and the 0x20 escape mask;
  - the FSM state encoding (NORMAL, ESC, CHAN, CHAN_ESC);
  - the FIFO-word field layout.
- One sub-module, peridot_pkt_fifo: parameterised width/depth, FWFT, async active-low reset, with a write-accepted output used for the overflow pulse.

## Test plan
- Plain packet, out_ready=1:
  - Stimulus: 7A 01 02 7B 03.
  - Response: 3 beats, 01(sop) 02 03(eop), channel 0, first out_valid one cycle after the 01 strobe.
- Escapes:
  - Stimulus: 7A 7D 5A 7D 5D 7B 7D 5B.
  - Response: beats 7A(sop) 7D 7B(eop).
- Channel:
  - Stimulus: 7C 05 7A 11 7B 22, then 7C 7D 5C 33.
  - Response: 11(sop, ch5) 22(eop, ch5) 33(ch 0x7C truncated to CHANNEL_WIDTH).
  - Macro undefined: all beats have ch 0 and the same data.
- Overflow with FIFO_DEPTH_LOG2=2 and out_ready=0:
  - Stimulus: six data bytes 10..15.
  - Response: err_overflow pulses on the 14 and 15 strobes. After out_ready=1, exactly 10 11 12 13 appear.
- Backpressure:
  - Stimulus: toggle out_ready randomly during a 40-byte packet.
  - Response: no loss or reorder; fields stay stable while stalled.
- Reset mid-stream:
  - Stimulus: drop reset_n after 7C (and separately after 7D with the FIFO holding 3 entries).
  - Response: all outputs 0 immediately. Following 41 gives a plain data beat 41 on ch 0 with no sop.

Source files
------------

// File: rtl/peridot_pkt_pkg.sv
// Shared definitions for the PERIDOT host-link receive packetizer:
// framing byte values, decoder state encoding and FIFO word layout.
// Build option: PERIDOT_RXD_PACKETIZER_CHANNEL_EN widens the FIFO word with a channel field.
package peridot_pkt_pkg;

    // Framing bytes of the escape-coded host link
    localparam logic [7:0] SOP_BYTE  = 8'h7A;
    localparam logic [7:0] EOP_BYTE  = 8'h7B;
    localparam logic [7:0] CHAN_BYTE = 8'h7C;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_MASK  = 8'h20;

    // Decoder states
    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_ESC      = 2'd1,
        ST_CHAN     = 2'd2,
        ST_CHAN_ESC = 2'd3
    } dec_state_t;

    // FIFO word layout: {channel (optional), sop, eop, data}
    localparam int FW_DATA_LSB = 0;
    localparam int FW_DATA_W   = 8;
    localparam int FW_EOP_BIT  = 8;
    localparam int FW_SOP_BIT  = 9;
    localparam int FW_CHAN_LSB = 10;
    localparam int FW_BASE_W   = 10;

endpackage

// File: rtl/peridot_pkt_fifo.sv
// First-word-fall-through FIFO for decoded packet beats.
// The head entry is presented on rd_data whenever rd_valid is high.
// wr_accept reports whether a write request was stored this cycle; a write
// into a full FIFO is still accepted when the head is read in the same cycle.
module peridot_pkt_fifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_accept,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                empty;
    logic                full;
    logic                rd_fire;

    // Extra pointer MSB separates full from empty when the indices match
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
        rd_fire   = rd_en && !empty;
        wr_accept = wr_en && (!full || rd_fire);
        rd_valid  = !empty;
        rd_data   = mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    // Storage and pointers; storage is cleared so the head reads as zero after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_accept) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/peridot_rxd_packetizer.sv
// Receive-side packetizer for the PERIDOT host link. Decodes the escape-coded
// byte stream from the UART phy into Avalon-ST beats with SOP/EOP/channel and
// buffers them in a FWFT FIFO; a beat that finds the FIFO full is dropped and
// flagged on err_overflow in the same cycle.
// Build option: define PERIDOT_RXD_PACKETIZER_CHANNEL_EN to decode channel
// bytes; otherwise channel bytes are consumed and out_channel is tied to 0.
module peridot_rxd_packetizer
    import peridot_pkt_pkg::*;
#(
    parameter int CHANNEL_WIDTH   = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     err_overflow
);

`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
    localparam int WORD_W = FW_BASE_W + CHANNEL_WIDTH;
`else
    localparam int WORD_W = FW_BASE_W;
`endif

    dec_state_t        state;
    dec_state_t        state_nxt;
    logic              sop_pend;
    logic              eop_pend;
    logic              set_sop;
    logic              set_eop;
    logic              push;
    logic [7:0]        push_byte;
    logic [7:0]        esc_data;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              wr_accept;
    logic              rd_fire;

`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
    logic                     chan_load;
    logic [CHANNEL_WIDTH-1:0] chan_nxt;
    logic [CHANNEL_WIDTH-1:0] cur_chan;
`endif

    assign esc_data = in_data ^ ESC_MASK;

    // Decoder next state and per-byte actions; nothing happens without in_valid
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_byte = in_data;
        set_sop   = 1'b0;
        set_eop   = 1'b0;
`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
        chan_load = 1'b0;
        chan_nxt  = in_data[CHANNEL_WIDTH-1:0];
`endif
        if (in_valid) begin
            case (state)
                ST_NORMAL: begin
                    if (in_data == SOP_BYTE) begin
                        set_sop = 1'b1;
                    end else if (in_data == EOP_BYTE) begin
                        set_eop = 1'b1;
                    end else if (in_data == CHAN_BYTE) begin
                        state_nxt = ST_CHAN;
                    end else if (in_data == ESC_BYTE) begin
                        state_nxt = ST_ESC;
                    end else begin
                        push = 1'b1;
                    end
                end
                ST_ESC: begin
                    push      = 1'b1;
                    push_byte = esc_data;
                    state_nxt = ST_NORMAL;
                end
                ST_CHAN: begin
                    if (in_data == ESC_BYTE) begin
                        state_nxt = ST_CHAN_ESC;
                    end else begin
`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
                        chan_load = 1'b1;
`endif
                        state_nxt = ST_NORMAL;
                    end
                end
                ST_CHAN_ESC: begin
`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
                    chan_load = 1'b1;
                    chan_nxt  = esc_data[CHANNEL_WIDTH-1:0];
`endif
                    state_nxt = ST_NORMAL;
                end
                default: state_nxt = ST_NORMAL;
            endcase
        end
    end

    // Decoder state and pending marker flags; a push consumes the flags even if dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_NORMAL;
            sop_pend <= 1'b0;
            eop_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                sop_pend <= 1'b0;
                eop_pend <= 1'b0;
            end else begin
                sop_pend <= sop_pend | set_sop;
                eop_pend <= eop_pend | set_eop;
            end
        end
    end

`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
    // Current channel, held until the next channel byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_chan <= '0;
        end else if (chan_load) begin
            cur_chan <= chan_nxt;
        end
    end
`endif

    // Assemble the FIFO word from the decoded byte and the packet context
    always_comb begin
        wr_word = '0;
        wr_word[FW_DATA_LSB +: FW_DATA_W] = push_byte;
        wr_word[FW_EOP_BIT]               = eop_pend;
        wr_word[FW_SOP_BIT]               = sop_pend;
`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
        wr_word[FW_CHAN_LSB +: CHANNEL_WIDTH] = cur_chan;
`endif
    end

    assign rd_fire = out_valid && out_ready;

    peridot_pkt_fifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (push),
        .wr_data   (wr_word),
        .wr_accept (wr_accept),
        .rd_en     (rd_fire),
        .rd_valid  (out_valid),
        .rd_data   (rd_word)
    );

    // Output fields come straight from the FIFO head entry
    always_comb begin
        out_data          = rd_word[FW_DATA_LSB +: FW_DATA_W];
        out_startofpacket = rd_word[FW_SOP_BIT];
        out_endofpacket   = rd_word[FW_EOP_BIT];
`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
        out_channel       = rd_word[FW_CHAN_LSB +: CHANNEL_WIDTH];
`else
        out_channel       = '0;
`endif
        err_overflow      = push && !wr_accept;
    end

endmodule

// File: tb/tb_peridot_rxd_packetizer.sv
// Self-checking bench for peridot_rxd_packetizer (4-bit channel, 4-entry FIFO).
module tb_peridot_rxd_packetizer;

    localparam int CW    = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef PERIDOT_RXD_PACKETIZER_CHANNEL_EN
    localparam logic [7:0] CHMASK = 8'h0F;
`else
    localparam logic [7:0] CHMASK = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [CW-1:0] out_channel;
    logic          err_overflow;

    peridot_rxd_packetizer #(
        .CHANNEL_WIDTH   (CW),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .out_channel       (out_channel),
        .err_overflow      (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] ch;
        logic [7:0] d;
    } beat_t;

    int nvec = 0;
    int nerr = 0;

    // Reference model: packet context plus a queue standing in for the FIFO
    beat_t      mq[$];
    bit         m_in_esc, m_in_chan, m_chan_esc, m_sop, m_eop;
    logic [7:0] m_ch;

    beat_t got[$];
    beat_t expq[$];

    logic       s_valid, s_sop, s_eop, s_ovf;
    logic [7:0] s_data, s_ch;
    bit         prev_stall;
    beat_t      prev_beat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_in_esc = 0; m_in_chan = 0; m_chan_esc = 0; m_sop = 0; m_eop = 0;
        m_ch = 8'h00;
        prev_stall = 0;
    endtask

    // Apply the framing rules to one received byte
    task automatic model_byte(input logic [7:0] d, output bit push, output beat_t b);
        logic [7:0] v;
        push = 0;
        b = '0;
        v = 8'h00;
        if (m_in_chan) begin
            if (!m_chan_esc && d == 8'h7D) begin
                m_chan_esc = 1;
            end else begin
                m_ch = (m_chan_esc ? (d ^ 8'h20) : d) & CHMASK;
                m_in_chan = 0;
                m_chan_esc = 0;
            end
        end else if (m_in_esc) begin
            v = d ^ 8'h20;
            push = 1;
            m_in_esc = 0;
        end else if (d == 8'h7A) m_sop = 1;
        else if (d == 8'h7B) m_eop = 1;
        else if (d == 8'h7C) m_in_chan = 1;
        else if (d == 8'h7D) m_in_esc = 1;
        else begin
            v = d;
            push = 1;
        end
        if (push) begin
            b = '{sop: m_sop, eop: m_eop, ch: m_ch, d: v};
            m_sop = 0;
            m_eop = 0;
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model, advance
    task automatic step(input bit iv, input logic [7:0] d, input bit rdy);
        bit    push;
        beat_t b;
        bit    exp_ovf;
        beat_t cur;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        s_valid = out_valid; s_data = out_data; s_sop = out_startofpacket;
        s_eop = out_endofpacket; s_ch = 8'(out_channel); s_ovf = err_overflow;
        cur = '{sop: s_sop, eop: s_eop, ch: s_ch, d: s_data};
        push = 0;
        b = '0;
        if (iv) model_byte(d, push, b);
        exp_ovf = push && (mq.size() == DEPTH) && !rdy;
        chk("err_overflow", 32'(s_ovf), 32'(exp_ovf));
        chk("out_valid", 32'(s_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("head_beat", 32'(cur), 32'(mq[0]));
        if (prev_stall) chk("stall_stable", 32'(cur), 32'(prev_beat));
        prev_stall = s_valid && !rdy;
        prev_beat  = cur;
        if (s_valid && rdy) got.push_back(cur);
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (push && mq.size() < DEPTH) mq.push_back(b);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 0);
        chk({nm, "_data"}, 32'(out_data), 0);
        chk({nm, "_sop"}, 32'(out_startofpacket), 0);
        chk({nm, "_eop"}, 32'(out_endofpacket), 0);
        chk({nm, "_chan"}, 32'(out_channel), 0);
        chk({nm, "_ovf"}, 32'(err_overflow), 0);
    endtask

    // Asynchronous reset from wherever we are in the cycle
    task automatic do_reset(input string nm);
        in_valid = 0;
        reset_n = 0;
        #1;
        check_reset_outputs(nm);
        model_clear();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string nm);
        chk({nm, "_count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk({nm, "_beat"}, 32'(got[i]), 32'(expq[i]));
    endtask

    typedef struct {
        bit         rst;
        bit         iv;
        logic [7:0] d;
        bit         rdy;
        bit         ev;
        logic [7:0] ed;
        bit         es;
        bit         ee;
        bit         eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit iv, logic [7:0] d, bit rdy,
                                bit ev, logic [7:0] ed, bit es, bit ee, bit eo);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.es = es; v.ee = ee; v.eo = eo;
        return v;
    endfunction

    initial begin
        // Plain packet: 7A 01 02 7B 03
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7A, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h01, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 1, 1, 8'h01, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7B, 1, 1, 8'h02, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h03, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h03, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        // Escapes: 7A 7D 5A 7D 5D 7B 7D 5B
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7A, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7D, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5A, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7D, 1, 1, 8'h7A, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5D, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7B, 1, 1, 8'h7D, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h7D, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5B, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h7B, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0));
        // Overflow: 10..15 with out_ready=0, then drain
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h12, 0, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h13, 0, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h14, 0, 1, 8'h10, 0, 0, 1));
        tbl.push_back(mk(0, 1, 8'h15, 0, 1, 8'h10, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h12, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h13, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0));

        model_clear();
        got.delete();
        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;

        // Table-driven cycle-exact vectors
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                do_reset("tbl_reset");
            end else begin
                step(tbl[i].iv, tbl[i].d, tbl[i].rdy);
                chk("tbl_valid", 32'(s_valid), 32'(tbl[i].ev));
                chk("tbl_ovf", 32'(s_ovf), 32'(tbl[i].eo));
                if (tbl[i].ev) begin
                    chk("tbl_data", 32'(s_data), 32'(tbl[i].ed));
                    chk("tbl_sop", 32'(s_sop), 32'(tbl[i].es));
                    chk("tbl_eop", 32'(s_eop), 32'(tbl[i].ee));
                    chk("tbl_chan", 32'(s_ch), 0);
                end
            end
        end

        // Channel decoding, including an escaped channel byte
        do_reset("chan_reset");
        got.delete();
        expq.delete();
        begin
            logic [7:0] seq [10];
            seq = '{8'h7C, 8'h05, 8'h7A, 8'h11, 8'h7B, 8'h22, 8'h7C, 8'h7D, 8'h5C, 8'h33};
            for (int i = 0; i < 10; i++) step(1, seq[i], 1);
        end
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        expq.push_back('{sop: 1, eop: 0, ch: 8'h05 & CHMASK, d: 8'h11});
        expq.push_back('{sop: 0, eop: 1, ch: 8'h05 & CHMASK, d: 8'h22});
        expq.push_back('{sop: 0, eop: 0, ch: 8'h7C & CHMASK, d: 8'h33});
        check_got("chan");

        // Push into a full FIFO while the head is read is kept
        do_reset("full_rd_reset");
        got.delete();
        expq.delete();
        for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0);
        step(1, 8'h24, 1);
        chk("full_rd_ovf", 32'(s_ovf), 0);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 5; i++) expq.push_back('{sop: 0, eop: 0, ch: 8'h00, d: 8'(8'h20 + i)});
        check_got("full_rd");

        // Backpressure: 40-byte packet with random out_ready, paced to avoid overflow
        do_reset("bp_reset");
        got.delete();
        expq.delete();
        step(1, 8'h7A, $urandom_range(0, 1));
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 8'h79));
            if (i == 39) step(1, 8'h7B, $urandom_range(0, 1));
            step(1, b, $urandom_range(0, 1));
            expq.push_back('{sop: (i == 0), eop: (i == 39), ch: 8'h00, d: b});
            for (int k = 0; k < 20 && mq.size() >= DEPTH - 1; k++) step(0, 8'h00, $urandom_range(0, 1));
        end
        for (int k = 0; k < 30 && mq.size() != 0; k++) step(0, 8'h00, $urandom_range(0, 1));
        step(0, 8'h00, 1);
        check_got("backpressure");

        // Random soak against the model, with framing bytes made frequent
        do_reset("soak_reset");
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 9) < 4) b = 8'(8'h7A + $urandom_range(0, 3));
            else b = 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) != 0);
        end

        // Reset right after a channel prefix
        do_reset("mid_reset_pre");
        step(1, 8'h7A, 0);
        step(1, 8'h01, 0);
        step(1, 8'h7C, 0);
        #2;
        do_reset("reset_after_chan");
        got.delete();
        expq.delete();
        step(1, 8'h41, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        expq.push_back('{sop: 0, eop: 0, ch: 8'h00, d: 8'h41});
        check_got("after_chan_reset");

        // Reset right after an escape with three entries queued
        step(1, 8'h50, 0);
        step(1, 8'h51, 0);
        step(1, 8'h52, 0);
        step(1, 8'h7D, 0);
        #2;
        do_reset("reset_after_esc");
        got.delete();
        step(1, 8'h41, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        check_got("after_esc_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
